// File: rtl/rom_scan_reader.sv
// Walks an inclusive, wrapping address range of a combinational ROM, waits a
// settle interval per address, and streams each captured word with a checksum.
module rom_scan_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DWELL  = 1
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, DONE} state_t;

  state_t            state;
  logic [3:0]        dwell;
  logic [ADDR_W-1:0] last_q;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dwell     <= '0;
      last_q    <= '0;
      rom_addr  <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            last_q   <= last_addr;
            rom_addr <= first_addr;
            checksum <= '0;
            dwell    <= 4'(DWELL);
            busy     <= 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          dwell <= dwell - 1'b1;
          // Counter hits zero on this edge: the ROM output has settled.
          if (dwell == 4'd1) begin
            out_data  <= rom_data;
            out_addr  <= rom_addr;
            checksum  <= checksum + rom_data;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (rom_addr == last_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              dwell    <= 4'(DWELL);
              state    <= SETTLE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_scan_reader.sv
// Directed bench for rom_scan_reader: table of scan ranges plus backpressure,
// ignored-start and mid-scan reset sequences against a {addr,~addr} ROM.
module tb_rom_scan_reader;

  logic       sysclk = 1'b0;
  logic       reset, start, out_ready;
  logic [3:0] first_addr, last_addr, rom_addr, out_addr;
  logic [7:0] rom_data, out_data, checksum;
  logic       out_valid, busy, done;

  int checks = 0;
  int errors = 0;

  rom_scan_reader #(.ADDR_W(4), .DATA_W(8), .DWELL(1)) dut (
    .sysclk(sysclk), .reset(reset), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .checksum(checksum)
  );

  assign rom_data = {rom_addr, ~rom_addr};

  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_checksum"}, checksum, 0);
  endtask

  // Runs one scan; all decisions are made at negedges, the DUT acts at posedges.
  task automatic run_scan(input logic [3:0] f, input logic [3:0] l, input int n_exp,
                          input logic [7:0] cs_exp, input int bp_addr, input int bp_cycles,
                          input bit dup_start, input bit check_rate);
    int idx, last_acc, bp_left, cyc;
    bit fin, dup_done;
    logic [3:0] ea, h_addr, h_rom;
    logic [7:0] h_data;
    @(negedge sysclk);
    first_addr = f; last_addr = l; start = 1'b1; out_ready = 1'b1;
    @(negedge sysclk);
    start = 1'b0; first_addr = ~f; last_addr = ~l;
    chk("busy_after_start", busy, 1);
    idx = 0; last_acc = -10; bp_left = bp_cycles; fin = 0; dup_done = 0;
    h_addr = '0; h_rom = '0; h_data = '0;
    for (cyc = 0; cyc < 400 && !fin; cyc++) begin
      start = 1'b0;
      if (done) begin
        chk("done_timing", cyc - last_acc, 1);
        chk("busy_at_done", busy, 0);
        chk("checksum", checksum, cs_exp);
        chk("word_count", idx, n_exp);
        fin = 1;
      end else if (out_valid) begin
        if (bp_addr >= 0 && out_addr == bp_addr[3:0] && bp_left > 0) begin
          if (bp_left == bp_cycles) begin
            h_addr = out_addr; h_data = out_data; h_rom = rom_addr;
          end else begin
            chk("bp_out_data", out_data, h_data);
            chk("bp_out_addr", out_addr, h_addr);
            chk("bp_rom_addr", rom_addr, h_rom);
          end
          out_ready = 1'b0;
          bp_left--;
        end else begin
          out_ready = 1'b1;
          ea = f + idx[3:0];
          chk("word_addr", out_addr, ea);
          chk("word_data", out_data, {ea, ~ea});
          if (check_rate && idx > 0) chk("word_rate", cyc - last_acc, 2);
          last_acc = cyc;
          idx++;
        end
        if (dup_start && out_addr == 4'd3 && !dup_done) begin
          first_addr = 4'd8; last_addr = 4'd9; start = 1'b1; dup_done = 1;
        end
      end
      if (!fin) @(negedge sysclk);
    end
    start = 1'b0;
    if (!fin) chk("scan_timeout", 0, 1);
    if (bp_cycles > 0) chk("bp_cycles_used", bp_left, 0);
    repeat (3) begin
      @(negedge sysclk);
      chk("done_single", done, 0);
      chk("idle_busy", busy, 0);
    end
    chk("checksum_hold", checksum, cs_exp);
  endtask

  typedef struct {
    logic [3:0] f;
    logic [3:0] l;
    int         n;
    logic [7:0] cs;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{4'd0,  4'd15, 16, 8'hF8};
    vecs[1] = '{4'd14, 4'd1,  4,  8'hFE};
    vecs[2] = '{4'd5,  4'd5,  1,  8'h5A};
    vecs[3] = '{4'd3,  4'd6,  4,  8'h4A};
    vecs[4] = '{4'd15, 4'd0,  2,  8'hFF};

    reset = 1'b1; start = 1'b0; out_ready = 1'b0; first_addr = '0; last_addr = '0;
    repeat (2) @(negedge sysclk);
    chk_reset_vals("reset");
    reset = 1'b0;

    for (int i = 0; i < 5; i++)
      run_scan(vecs[i].f, vecs[i].l, vecs[i].n, vecs[i].cs, -1, 0, 0, 1);

    // Backpressure on the word from address 7.
    run_scan(4'd0, 4'd15, 16, 8'hF8, 7, 10, 0, 0);

    // Start pulse while the scan sits on address 3 must be ignored.
    run_scan(4'd0, 4'd15, 16, 8'hF8, -1, 0, 1, 1);

    // Reset while presenting address 9.
    @(negedge sysclk);
    first_addr = 4'd0; last_addr = 4'd15; start = 1'b1; out_ready = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    begin
      bit hit;
      hit = 0;
      for (int c = 0; c < 100 && !hit; c++) begin
        if (out_valid && out_addr == 4'd9) begin
          out_ready = 1'b0; hit = 1;
        end else begin
          out_ready = 1'b1;
          @(negedge sysclk);
        end
      end
      chk("reach_addr9", hit, 1);
    end
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_reset");
    repeat (2) begin
      @(negedge sysclk);
      chk("reset_no_done", done, 0);
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge sysclk);
      chk("post_reset_no_done", done, 0);
    end
    run_scan(4'd0, 4'd15, 16, 8'hF8, -1, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
